// File: rtl/boolnet_run_if.sv
// boolnet_run_if: host handshake and network-core signals of the run controller
interface boolnet_run_if #(
  parameter int N_NODES   = 9,
  parameter int N_INPUTS  = 1,
  parameter int MAX_STEPS = 1024,
  parameter int STEP_W    = $clog2(MAX_STEPS + 1)
);
  logic                start;
  logic [1:0]          mode;
  logic [N_NODES-1:0]  init_state;
  logic [N_INPUTS-1:0] init_inputs;
  logic                abort;
  logic [N_NODES-1:0]  next_state;
  logic [N_NODES-1:0]  state;
  logic [N_INPUTS-1:0] net_inputs;
  logic                busy;
  logic                done;
  logic [2:0]          result;
  logic [STEP_W-1:0]   steps;
  logic [STEP_W-1:0]   period;
  modport master (
    output start, mode, init_state, init_inputs, abort, next_state,
    input  state, net_inputs, busy, done, result, steps, period
  );
  modport slave (
    input  start, mode, init_state, init_inputs, abort, next_state,
    output state, net_inputs, busy, done, result, steps, period
  );
endinterface

// File: rtl/boolnet_run_controller.sv
// boolnet_run_controller: runs a Boolean network to fixed point, cycle, timeout or abort
module boolnet_run_controller #(
  parameter int N_NODES   = 9,
  parameter int N_INPUTS  = 1,
  parameter int MAX_STEPS = 1024,
  parameter int STEP_W    = $clog2(MAX_STEPS + 1)
) (
  input logic          clk,
  input logic          rst,
  boolnet_run_if.slave bus
);
  localparam int PTR_W = N_NODES > 1 ? $clog2(N_NODES) : 1;
  localparam logic [STEP_W-1:0] MAX_C = STEP_W'(MAX_STEPS);
  localparam logic [2:0] R_NONE = 3'd0, R_FIXED = 3'd1, R_CYCLE = 3'd2, R_TIMEOUT = 3'd3, R_ABORT = 3'd4;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} fsm_t;
  fsm_t                fsm_q, fsm_d;
  logic [N_NODES-1:0]  state_q, state_d, snap_q, snap_d, ns;
  logic [N_INPUTS-1:0] inp_q, inp_d;
  logic                async_q, async_d;
  logic [2:0]          result_q, result_d;
  logic [STEP_W-1:0]   steps_q, steps_d, period_q, period_d, power_q, power_d, lam_q, lam_d, lam_n;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  always_comb begin
    fsm_d    = fsm_q;
    state_d  = state_q;
    snap_d   = snap_q;
    inp_d    = inp_q;
    async_d  = async_q;
    result_d = result_q;
    steps_d  = steps_q;
    period_d = period_q;
    power_d  = power_q;
    lam_d    = lam_q;
    ptr_d    = ptr_q;
    ns       = state_q;
    ns[ptr_q] = bus.next_state[ptr_q];
    ns       = async_q ? ns : bus.next_state;
    lam_n    = lam_q + STEP_W'(1);
    case (fsm_q)
      IDLE: if (bus.start) begin
        fsm_d    = LOAD;
        async_d  = bus.mode == 2'd1;
        state_d  = bus.init_state;
        inp_d    = bus.init_inputs;
        steps_d  = '0;
        period_d = '0;
        result_d = R_NONE;
      end
      LOAD: begin
        fsm_d   = RUN;
        ptr_d   = '0;
        lam_d   = '0;
        power_d = STEP_W'(1);
        snap_d  = state_q;
      end
      RUN: if (bus.abort) begin
        fsm_d    = DONE;
        result_d = R_ABORT;
      end else if (bus.next_state == state_q) begin
        fsm_d    = DONE;
        result_d = R_FIXED;
      end else if (steps_q == MAX_C) begin
        fsm_d    = DONE;
        result_d = R_TIMEOUT;
      end else begin
        state_d = ns;
        steps_d = steps_q + STEP_W'(1);
        if (async_q) begin
          ptr_d = ptr_q == PTR_W'(N_NODES - 1) ? '0 : ptr_q + PTR_W'(1);
        end else if (ns == snap_q) begin
          fsm_d    = DONE;
          result_d = R_CYCLE;
          period_d = lam_n;
        end else if (lam_n == power_q) begin
          snap_d  = ns;
          power_d = power_q > (MAX_C >> 1) ? MAX_C : power_q << 1;
          lam_d   = '0;
        end else begin
          lam_d = lam_n;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q    <= IDLE;
      state_q  <= '0;
      snap_q   <= '0;
      inp_q    <= '0;
      async_q  <= 1'b0;
      result_q <= R_NONE;
      steps_q  <= '0;
      period_q <= '0;
      power_q  <= '0;
      lam_q    <= '0;
      ptr_q    <= '0;
    end else begin
      fsm_q    <= fsm_d;
      state_q  <= state_d;
      snap_q   <= snap_d;
      inp_q    <= inp_d;
      async_q  <= async_d;
      result_q <= result_d;
      steps_q  <= steps_d;
      period_q <= period_d;
      power_q  <= power_d;
      lam_q    <= lam_d;
      ptr_q    <= ptr_d;
    end
  end
  assign bus.state      = state_q;
  assign bus.net_inputs = inp_q;
  assign bus.result     = result_q;
  assign bus.steps      = steps_q;
  assign bus.period     = period_q;
  assign bus.busy       = fsm_q == LOAD || fsm_q == RUN;
  assign bus.done       = fsm_q == DONE;
endmodule
